// File: rtl/multiword_add_seq_pkg.sv
// mwadd_pkg: shared types for the multi-word add sequencer.
// Build option: MWADD_SUB_EN adds subtract support (see multiword_add_seq.sv).
package mwadd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Chunk index width; a single-chunk build still needs one bit.
   function automatic int idx_width(input int words);
      return (words <= 1) ? 1 : $clog2(words);
   endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for multiword_add_seq.
// Build option: MWADD_SUB_EN adds the sub request line.
interface multiword_add_seq_if #(
   parameter int N     = 8,
   parameter int WORDS = 4
);
   localparam int W = N * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef MWADD_SUB_EN
   logic         sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;

`ifdef MWADD_SUB_EN
   modport master (output in_valid, a, b, cin, sub, out_ready,
                   input  in_ready, out_valid, sum, cout);
   modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                   output in_ready, out_valid, sum, cout);
`else
   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/multiword_add_seq_rca.sv
// N-bit ripple-carry adder, the single arithmetic resource shared by all chunks.
module multiword_add_seq_rca #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co
);

   logic c;

   // Bit-serial carry chain, LSB first.
   always_comb begin
      s = '0;
      c = ci;
      for (int i = 0; i < N; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-word adder: W = N*WORDS bit sum computed one N-bit chunk per cycle
// on one shared RCA, carry held in a register between chunks.
// Build option: MWADD_SUB_EN -- when defined, sub=1 on acceptance computes a-b
// (b stored inverted, carry seeded with 1, cin ignored; cout=1 means no borrow).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1, last result still visible
// RUN   | one chunk per cycle, idx 0..WORDS-1
// DONE  | result valid, held until out_ready
module multiword_add_seq
   import mwadd_pkg::*;
#(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   multiword_add_seq_if.slave  bus,
   output logic                busy
);

   localparam int             W    = N * WORDS;
   localparam int             IW   = idx_width(WORDS);
   localparam logic [IW-1:0]  LAST = IW'(WORDS - 1);

   state_t        state, state_nx;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_r, b_r, sum_r;
   logic          carry_r, cout_r, out_valid_r;
   logic [W-1:0]  b_in;
   logic          carry_in;
   logic [N-1:0]  a_chunk, b_chunk, rca_sum;
   logic          rca_cout;
   logic          accept, last;

   assign accept  = (state == IDLE) && bus.in_valid;
   assign last    = (idx == LAST);
   assign a_chunk = a_r[int'(idx) * N +: N];
   assign b_chunk = b_r[int'(idx) * N +: N];

   // Operand conditioning at acceptance; subtraction is a + ~b + 1.
   always_comb begin
      b_in     = bus.b;
      carry_in = bus.cin;
`ifdef MWADD_SUB_EN
      if (bus.sub) begin
         b_in     = ~bus.b;
         carry_in = 1'b1;
      end
`endif
   end

   multiword_add_seq_rca #(.N(N)) u_rca (
      .a  (a_chunk),
      .b  (b_chunk),
      .ci (carry_r),
      .s  (rca_sum),
      .co (rca_cout)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state decode.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nx = RUN;
         RUN:     if (last)          state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   // Datapath: operand capture, per-chunk writeback, result handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '0;
         a_r         <= '0;
         b_r         <= '0;
         carry_r     <= 1'b0;
         sum_r       <= '0;
         cout_r      <= 1'b0;
         out_valid_r <= 1'b0;
      end else if (accept) begin
         a_r     <= bus.a;
         b_r     <= b_in;
         carry_r <= carry_in;
         idx     <= '0;
      end else if (state == RUN) begin
         sum_r[int'(idx) * N +: N] <= rca_sum;
         carry_r                   <= rca_cout;
         if (last) begin
            cout_r      <= rca_cout;
            out_valid_r <= 1'b1;
         end else begin
            idx <= idx + 1'b1;
         end
      end else if ((state == DONE) && bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on each output handshake.
module tb_multiword_add_seq;

   localparam int N     = 8;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;

   always #5 clk = ~clk;

   multiword_add_seq_if #(.N(N), .WORDS(WORDS)) bus ();

   multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   last_hs  = 0;
   int   last_acc = 0;
   exp_t exp_q[$];
   int   acc_q[$];
   logic prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Monitor: latency on out_valid rise, result compare on output handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid && !prev_v) begin
            if (acc_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL latency out_valid rose with no pending acceptance");
            end else begin
               int a0;
               a0 = acc_q.pop_front();
               chk("latency", W'(cyc - a0), W'(WORDS));
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            last_hs = cyc;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL result unexpected output sum=%h", bus.sum);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sum",  {1'b0, bus.sum},      {1'b0, e.s});
               chk("cout", {{W{1'b0}}, bus.cout}, {{W{1'b0}}, e.c});
            end
         end
      end
      prev_v = bus.out_valid;
   end

   // Present operands, wait for acceptance, record expectation and accept cycle.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic [W-1:0] es, input logic ec,
                       input bit hold);
      int n;
      bus.a   = a;
      bus.b   = b;
      bus.cin = cin;
`ifdef MWADD_SUB_EN
      bus.sub = sub;
`else
      if (sub) $display("note: sub ignored in add-only build");
`endif
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout in_ready never rose a=%h", a);
         bus.in_valid = 1'b0;
         return;
      end
      exp_q.push_back('{s: es, c: ec});
      @(posedge clk); #1;
      acc_q.push_back(cyc);
      last_acc = cyc;
      if (!hold) bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_pending", W'(exp_q.size()), '0);
   endtask

   initial begin
      int n;
      int a1;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
`ifdef MWADD_SUB_EN
      bus.sub       = 1'b0;
`endif
      #12;
      chk("rst_in_ready",  {{W{1'b0}}, bus.in_ready},  1);
      chk("rst_out_valid", {{W{1'b0}}, bus.out_valid}, 0);
      chk("rst_sum",       {1'b0, bus.sum},            0);
      chk("rst_cout",      {{W{1'b0}}, bus.cout},      0);
      chk("rst_busy",      {{W{1'b0}}, busy},          0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic carry across a chunk boundary, then full 4-chunk ripple.
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      drain();
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      drain();

      // Backpressure: result held, new operands wait for the output handshake.
      bus.out_ready = 1'b0;
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_valid_rise", {{W{1'b0}}, bus.out_valid}, 1);
      bus.a        = 32'h8000_0000;
      bus.b        = 32'h8000_0000;
      bus.cin      = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", {{W{1'b0}}, bus.out_valid}, 1);
         chk("bp_in_ready",  {{W{1'b0}}, bus.in_ready},  0);
         chk("bp_sum",       {1'b0, bus.sum},            {1'b0, 32'h2345_6789});
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
      chk("bp_accept_after_hs", W'(last_acc - last_hs), W'(2));
      drain();

      // Reset mid-operation at idx=2: asynchronous clear of all outputs.
      send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {{W{1'b0}}, bus.out_valid}, 0);
      chk("abort_sum",       {1'b0, bus.sum},            0);
      chk("abort_cout",      {{W{1'b0}}, bus.cout},      0);
      chk("abort_in_ready",  {{W{1'b0}}, bus.in_ready},  1);
      chk("abort_busy",      {{W{1'b0}}, busy},          0);
      exp_q.delete();
      acc_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(32'd5, 32'd7, 1'b0, 1'b0, 32'd12, 1'b0, 1'b0);
      drain();

      // Back-to-back with in_valid held: initiation interval WORDS+2.
      send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      a1 = last_acc;
      send(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("b2b_interval", W'(last_acc - a1), W'(WORDS + 2));
      drain();

`ifdef MWADD_SUB_EN
      send(32'd10, 32'd3, 1'b0, 1'b1, 32'd7, 1'b1, 1'b0);
      drain();
      send(32'd3, 32'd10, 1'b1, 1'b1, 32'hFFFF_FFF9, 1'b0, 1'b0);
      drain();
      send(32'd3, 32'd10, 1'b0, 1'b0, 32'd13, 1'b0, 1'b0);
      drain();
`endif

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
